// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 16-bit pipelined core.
// Retires non-memory ops in one cycle, and runs LOAD/STORE over a
// request/ready handshake with a timeout abort. The writeback bundle
// is registered and fed back to Decode.
module mem_stage #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter logic [3:0]  LOAD_OP     = 4'b1100,
    parameter logic [3:0]  STORE_OP    = 4'b1110
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [4:0]  ex_control,
    input  logic [15:0] ex_result,
    input  logic [15:0] ex_store_data,
    input  logic [5:0]  ex_dest,
    input  logic        ex_write_enable,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_control,
    output logic [5:0]  wb_dest,
    output logic [15:0] wb_data,
    output logic        wb_write_enable,
    output logic        wb_error
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    // Counter value on the last tolerated WAIT edge; the next ready-less
    // edge brings the count to MEM_TIMEOUT and aborts the access.
    localparam logic [7:0] LP_CNT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [0:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic [4:0]  r_cap_control;
    logic [5:0]  r_cap_dest;
    logic        r_cap_we;
    logic        r_wb_valid;
    logic [4:0]  r_wb_control;
    logic [5:0]  r_wb_dest;
    logic [15:0] r_wb_data;
    logic        r_wb_write_enable;
    logic        r_wb_error;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;

    // Opcode decode of the instruction currently presented by Execute
    always_comb begin
        w_is_load  = (ex_control[3:0] == LOAD_OP);
        w_is_store = (ex_control[3:0] == STORE_OP);
        w_is_mem   = w_is_load || w_is_store;
    end

    // Stage state machine: accept, memory handshake, timeout and writeback
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_cnt             <= '0;
            r_mem_req         <= 1'b0;
            r_mem_we          <= 1'b0;
            r_mem_addr        <= '0;
            r_mem_wdata       <= '0;
            r_cap_control     <= '0;
            r_cap_dest        <= '0;
            r_cap_we          <= 1'b0;
            r_wb_valid        <= 1'b0;
            r_wb_control      <= '0;
            r_wb_dest         <= '0;
            r_wb_data         <= '0;
            r_wb_write_enable <= 1'b0;
            r_wb_error        <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_wb_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ex_valid) begin
                        if (w_is_mem) begin
                            r_mem_req     <= 1'b1;
                            r_mem_we      <= w_is_store;
                            r_mem_addr    <= ex_result;
                            r_mem_wdata   <= w_is_store ? ex_store_data : '0;
                            r_cap_control <= ex_control;
                            r_cap_dest    <= ex_dest;
                            r_cap_we      <= ex_write_enable;
                            r_cnt         <= '0;
                            r_state       <= S_WAIT;
                        end else begin
                            r_wb_valid        <= 1'b1;
                            r_wb_control      <= ex_control;
                            r_wb_dest         <= ex_dest;
                            r_wb_data         <= ex_result;
                            r_wb_write_enable <= ex_write_enable;
                        end
                    end
                end
                default: begin
                    // Completion is checked first so a ready on the
                    // timeout edge still retires cleanly.
                    if (mem_ready) begin
                        r_mem_req         <= 1'b0;
                        r_state           <= S_IDLE;
                        r_wb_valid        <= 1'b1;
                        r_wb_control      <= r_cap_control;
                        r_wb_dest         <= r_cap_dest;
                        r_wb_data         <= r_mem_we ? r_mem_addr : mem_rdata;
                        r_wb_write_enable <= r_mem_we ? 1'b0 : r_cap_we;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == LP_CNT_LAST) begin
                            r_mem_req         <= 1'b0;
                            r_state           <= S_IDLE;
                            r_wb_valid        <= 1'b1;
                            r_wb_error        <= 1'b1;
                            r_wb_control      <= r_cap_control;
                            r_wb_dest         <= r_cap_dest;
                            r_wb_data         <= '0;
                            r_wb_write_enable <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign stall           = (r_state == S_WAIT);
    assign mem_req         = r_mem_req;
    assign mem_we          = r_mem_we;
    assign mem_addr        = r_mem_addr;
    assign mem_wdata       = r_mem_wdata;
    assign wb_valid        = r_wb_valid;
    assign wb_control      = r_wb_control;
    assign wb_dest         = r_wb_dest;
    assign wb_data         = r_wb_data;
    assign wb_write_enable = r_wb_write_enable;
    assign wb_error        = r_wb_error;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a transaction-level
// reference model and literal spot checks.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [4:0]  ex_control;
    logic [15:0] ex_result;
    logic [15:0] ex_store_data;
    logic [5:0]  ex_dest;
    logic        ex_write_enable;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_control;
    logic [5:0]  wb_dest;
    logic [15:0] wb_data;
    logic        wb_write_enable;
    logic        wb_error;

    int checks   = 0;
    int failures = 0;

    mem_stage #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_control(ex_control),
        .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
        .ex_write_enable(ex_write_enable), .stall(stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
        .wb_control(wb_control), .wb_dest(wb_dest), .wb_data(wb_data),
        .wb_write_enable(wb_write_enable), .wb_error(wb_error)
    );

    always #5 clk = ~clk;

    // Reference model: one outstanding memory transaction at most.
    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        is_store;
        logic [4:0]  ctrl;
        logic [5:0]  dest;
        logic        we;
    } txn_t;

    txn_t        m_txn;
    logic        m_busy = 1'b0;
    int          m_waited = 0;
    logic        e_stall = 1'b0, e_req = 1'b0, e_we = 1'b0;
    logic [15:0] e_addr = '0, e_wdata = '0;
    logic        e_wbv = 1'b0, e_wbwe = 1'b0, e_err = 1'b0;
    logic [4:0]  e_ctrl = '0;
    logic [5:0]  e_dest = '0;
    logic [15:0] e_data = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0; m_waited <= 0;
            e_stall <= 1'b0; e_req <= 1'b0; e_we <= 1'b0; e_addr <= '0; e_wdata <= '0;
            e_wbv <= 1'b0; e_wbwe <= 1'b0; e_err <= 1'b0; e_ctrl <= '0; e_dest <= '0; e_data <= '0;
        end else begin
            e_wbv <= 1'b0;
            e_err <= 1'b0;
            if (m_busy) begin
                m_waited <= m_waited + 1;
                if (mem_ready || (m_waited + 1 >= TO)) begin
                    // transaction ends: completion or abort
                    m_busy  <= 1'b0;
                    e_stall <= 1'b0;
                    e_req   <= 1'b0;
                    e_wbv   <= 1'b1;
                    e_ctrl  <= m_txn.ctrl;
                    e_dest  <= m_txn.dest;
                    if (mem_ready) begin
                        e_data <= m_txn.is_store ? m_txn.addr : mem_rdata;
                        e_wbwe <= m_txn.is_store ? 1'b0 : m_txn.we;
                    end else begin
                        e_err  <= 1'b1;
                        e_data <= '0;
                        e_wbwe <= 1'b0;
                    end
                end
            end else if (ex_valid) begin
                if (ex_control[3:0] == 4'b1100 || ex_control[3:0] == 4'b1110) begin
                    m_txn.addr     <= ex_result;
                    m_txn.is_store <= (ex_control[3:0] == 4'b1110);
                    m_txn.wdata    <= (ex_control[3:0] == 4'b1110) ? ex_store_data : 16'h0;
                    m_txn.ctrl     <= ex_control;
                    m_txn.dest     <= ex_dest;
                    m_txn.we       <= ex_write_enable;
                    m_busy   <= 1'b1;
                    m_waited <= 0;
                    e_stall  <= 1'b1;
                    e_req    <= 1'b1;
                    e_we     <= (ex_control[3:0] == 4'b1110);
                    e_addr   <= ex_result;
                    e_wdata  <= (ex_control[3:0] == 4'b1110) ? ex_store_data : 16'h0;
                end else begin
                    e_wbv  <= 1'b1;
                    e_ctrl <= ex_control;
                    e_dest <= ex_dest;
                    e_data <= ex_result;
                    e_wbwe <= ex_write_enable;
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        check("stall", {15'b0, stall}, {15'b0, e_stall});
        check("mem_req", {15'b0, mem_req}, {15'b0, e_req});
        check("mem_we", {15'b0, mem_we}, {15'b0, e_we});
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_wdata);
        check("wb_valid", {15'b0, wb_valid}, {15'b0, e_wbv});
        check("wb_control", {11'b0, wb_control}, {11'b0, e_ctrl});
        check("wb_dest", {10'b0, wb_dest}, {10'b0, e_dest});
        check("wb_data", wb_data, e_data);
        check("wb_we", {15'b0, wb_write_enable}, {15'b0, e_wbwe});
        check("wb_error", {15'b0, wb_error}, {15'b0, e_err});
    endtask

    // One clock: edge, then compare outputs on the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [4:0] c, input logic [15:0] r,
                         input logic [15:0] sd, input logic [5:0] d, input logic we);
        ex_valid = v; ex_control = c; ex_result = r;
        ex_store_data = sd; ex_dest = d; ex_write_enable = we;
    endtask

    initial begin
        int n;
        reset = 1'b1; mem_ready = 1'b0; mem_rdata = '0;
        drive(1'b1, 5'h01, 16'h1111, 16'h0, 6'd1, 1'b1);

        // reset with a valid ADD presented
        cyc(); cyc();
        check("rst_stall", {15'b0, stall}, 16'h0);
        check("rst_wbv", {15'b0, wb_valid}, 16'h0);
        check("rst_req", {15'b0, mem_req}, 16'h0);
        check("rst_wbdata", wb_data, 16'h0);
        reset = 1'b0;
        drive(1'b0, 5'h0, 16'h0, 16'h0, 6'd0, 1'b0);
        cyc();

        // back-to-back ALU ops
        drive(1'b1, 5'h01, 16'h1234, 16'h0, 6'd5, 1'b1);
        cyc();
        check("add1_wbv", {15'b0, wb_valid}, 16'h1);
        check("add1_data", wb_data, 16'h1234);
        check("add1_dest", {10'b0, wb_dest}, 16'd5);
        drive(1'b1, 5'h01, 16'hBEEF, 16'h0, 6'd6, 1'b1);
        cyc();
        check("add2_wbv", {15'b0, wb_valid}, 16'h1);
        check("add2_data", wb_data, 16'hBEEF);
        check("add2_stall", {15'b0, stall}, 16'h0);
        drive(1'b0, 5'h0, 16'h0, 16'h0, 6'd0, 1'b0);
        cyc();
        check("idle_hold", wb_data, 16'hBEEF);

        // LOAD, ready on the third WAIT cycle
        drive(1'b1, 5'h0C, 16'h0040, 16'h5555, 6'd3, 1'b1);
        n = 0;
        cyc(); if (mem_req) n++;
        check("ld_addr", mem_addr, 16'h0040);
        check("ld_wdata", mem_wdata, 16'h0000);
        cyc(); if (mem_req) n++;
        cyc(); if (mem_req) n++;
        mem_ready = 1'b1; mem_rdata = 16'hCAFE;
        cyc(); if (mem_req) n++;
        check("ld_req_cycles", 16'(n), 16'd3);
        check("ld_data", wb_data, 16'hCAFE);
        check("ld_dest", {10'b0, wb_dest}, 16'd3);
        check("ld_we", {15'b0, wb_write_enable}, 16'h1);
        mem_ready = 1'b0; mem_rdata = 16'h0;
        drive(1'b1, 5'h03, 16'h7777, 16'h0, 6'd7, 1'b1);
        cyc();
        check("mov_data", wb_data, 16'h7777);
        drive(1'b0, 5'h0, 16'h0, 16'h0, 6'd0, 1'b0);
        cyc();

        // STORE with immediate ready
        drive(1'b1, 5'h0E, 16'h0010, 16'h00AA, 6'd2, 1'b1);
        n = 0;
        cyc(); if (stall) n++;
        check("st_we", {15'b0, mem_we}, 16'h1);
        check("st_wdata", mem_wdata, 16'h00AA);
        mem_ready = 1'b1;
        cyc(); if (stall) n++;
        check("st_stall_cycles", 16'(n), 16'd1);
        check("st_wbv", {15'b0, wb_valid}, 16'h1);
        check("st_wbwe", {15'b0, wb_write_enable}, 16'h0);
        check("st_data", wb_data, 16'h0010);
        mem_ready = 1'b0;
        drive(1'b0, 5'h0, 16'h0, 16'h0, 6'd0, 1'b0);
        cyc();

        // timeout
        drive(1'b1, 5'h0C, 16'h0080, 16'h0, 6'd4, 1'b1);
        n = 0;
        cyc(); if (mem_req) n++;
        for (int i = 0; i < TO; i++) begin
            cyc(); if (mem_req) n++;
        end
        check("to_req_cycles", 16'(n), 16'd4);
        check("to_err", {15'b0, wb_error}, 16'h1);
        check("to_wbwe", {15'b0, wb_write_enable}, 16'h0);
        check("to_data", wb_data, 16'h0);
        drive(1'b0, 5'h0, 16'h0, 16'h0, 6'd0, 1'b0);
        cyc();
        mem_ready = 1'b1; mem_rdata = 16'hDEAD;
        cyc();
        check("late_ready_wbv", {15'b0, wb_valid}, 16'h0);
        mem_ready = 1'b0;
        cyc();

        // ready arriving on the timeout edge: completion wins
        drive(1'b1, 5'h0C, 16'h0090, 16'h0, 6'd8, 1'b1);
        cyc();
        for (int i = 0; i < TO - 1; i++) cyc();
        mem_ready = 1'b1; mem_rdata = 16'h1357;
        cyc();
        check("edge_err", {15'b0, wb_error}, 16'h0);
        check("edge_data", wb_data, 16'h1357);
        mem_ready = 1'b0;
        drive(1'b0, 5'h0, 16'h0, 16'h0, 6'd0, 1'b0);
        cyc();

        // reset in the middle of an access
        drive(1'b1, 5'h0C, 16'h0100, 16'h0, 6'd9, 1'b1);
        cyc(); cyc();
        reset = 1'b1;
        drive(1'b0, 5'h0, 16'h0, 16'h0, 6'd0, 1'b0);
        cyc();
        check("mrst_req", {15'b0, mem_req}, 16'h0);
        check("mrst_stall", {15'b0, stall}, 16'h0);
        reset = 1'b0;
        cyc();
        check("mrst_wbv", {15'b0, wb_valid}, 16'h0);
        drive(1'b1, 5'h01, 16'h4242, 16'h0, 6'd10, 1'b1);
        cyc();
        check("post_add", wb_data, 16'h4242);
        drive(1'b0, 5'h0, 16'h0, 16'h0, 6'd0, 1'b0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
